pin_ctrl: RTL and testbench
===========================

PIN_CTRL -- requirements
Module: pin_ctrl

Interface
REQ-001 The parameter MAX_ATTEMPTS SHALL default to 3 and set the consecutive failed verifications that trigger lockout (range 1..3).
REQ-002 The parameter LOCKOUT_CYCLES SHALL default to 1024 and set the lockout duration in clk_i cycles (used only with PIN_LOCKOUT_TIMER_EN).
REQ-003 The port clk_i SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The port rst_ni SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 The port digit_i SHALL be an input, 4 bits: BCD digit from the keypad.
REQ-006 The port digit_valid_i SHALL be an input, 1 bit: single-cycle strobe qualifying digit_i.
REQ-007 The ports enter_i, clear_i and enroll_i SHALL be inputs, 1 bit each: single-cycle keypad command strobes.
REQ-008 The port key_i SHALL be an input, 16 bits: stored PIN read back from the key store.
REQ-009 The port key_blank_i SHALL be an input, 1 bit: high when the key store holds 16'h0000.
REQ-010 The port key_o SHALL be an output, 16 bits: PIN to write into the key store.
REQ-011 The port wenable_o SHALL be an output, 1 bit: key-store write strobe.
REQ-012 The ports unlock_o, fail_o and locked_o SHALL be outputs, 1 bit each: unlocked level, fail pulse and lockout level.
REQ-013 The port attempts_o SHALL be an output, 2 bits: current failed-attempt count.

Function
REQ-014 The FSM SHALL implement exactly these states: IDLE, COLLECT, CHECK, WRITE, UNLOCKED, LOCKOUT.
REQ-015 In IDLE/COLLECT, digit_valid_i with digit_i<=9 SHALL shift buf<={buf[11:0],digit_i} and increment cnt (saturating at 4), and the state SHALL become COLLECT.
REQ-016 Digits 10..15, and any digit arriving once cnt==4, SHALL be ignored.
REQ-017 Priority on coincident strobes SHALL be clear_i > enter_i > digit_valid_i, and the lower-priority strobes SHALL be dropped.
REQ-018 clear_i SHALL zero buf, cnt and the enroll flag and go to IDLE from COLLECT or UNLOCKED, and SHALL be ignored in CHECK, WRITE and LOCKOUT.
REQ-019 enroll_i SHALL set the enroll flag only in IDLE with key_blank_i=1 or in UNLOCKED, and SHALL be ignored otherwise.
REQ-020 Entering via enroll from UNLOCKED SHALL deassert unlock_o and go to IDLE with the enroll flag set.
REQ-021 enter_i with cnt<4 SHALL be ignored.
REQ-022 enter_i with cnt==4, enroll flag=0 and key_blank_i=0 SHALL go to CHECK.
REQ-023 enter_i with cnt==4, enroll flag=0 and key_blank_i=1 SHALL be ignored.
REQ-024 enter_i with cnt==4 and enroll flag=1 SHALL go to WRITE if buf!=0.
REQ-025 If buf==0 on an enroll enter, the block SHALL pulse fail_o for 1 cycle, return to IDLE and leave attempts unchanged (0 is reserved for blank).
REQ-026 CHECK SHALL last 1 cycle and compare buf with key_i.
REQ-027 On a CHECK match, the next state SHALL be UNLOCKED, unlock_o SHALL be 1 from that cycle until clear_i or enroll_i, and attempts SHALL be 0.
REQ-028 On a CHECK mismatch, fail_o SHALL pulse 1 cycle and attempts SHALL increment.
REQ-029 After a mismatch, the next state SHALL be LOCKOUT if the new attempts==MAX_ATTEMPTS, else IDLE.
REQ-030 WRITE SHALL last 1 cycle with wenable_o=1 and key_o=buf, then go to IDLE and clear the enroll flag and attempts.
REQ-031 key_o SHALL be 0 whenever wenable_o=0.
REQ-032 buf and cnt SHALL be zeroed on exit from CHECK and WRITE, so the PIN is never retained.
REQ-033 locked_o SHALL be 1 exactly while in LOCKOUT, and all strobes SHALL be ignored in LOCKOUT.
REQ-034 attempts_o SHALL equal the attempts register and SHALL saturate at MAX_ATTEMPTS.
REQ-035 Latency from enter_i to unlock_o or fail_o SHALL be 2 cycles, and from enter_i to wenable_o SHALL be 1 cycle.

Reset
REQ-036 rst_ni low SHALL asynchronously force IDLE, buf=0, cnt=0, enroll flag=0, attempts=0, lockout timer=0, and all outputs to 0.
REQ-037 Reset asserted mid-CHECK or mid-WRITE SHALL suppress the write strobe and the unlock.
REQ-038 Reset release SHALL be honoured on the next clk_i edge.

Configuration
REQ-039 With PIN_LOCKOUT_TIMER_EN defined, LOCKOUT SHALL load a counter with LOCKOUT_CYCLES-1 and decrement it each cycle.
REQ-040 With PIN_LOCKOUT_TIMER_EN defined, the block SHALL go to IDLE, with attempts cleared, on the cycle after the counter reaches 0.
REQ-041 Without PIN_LOCKOUT_TIMER_EN, LOCKOUT SHALL be exited only by rst_ni and no timer logic SHALL exist.

Verification
REQ-042 A bench SHALL cover: key_blank_i=1, enroll_i, digits 1,2,3,4, enter_i -> wenable_o=1 for 1 cycle with key_o=16'h1234, then IDLE.
REQ-043 A bench SHALL cover: key_i=16'h1234, digits 1,2,3,4, enter_i -> unlock_o=1 two cycles after enter_i, attempts_o=0.
REQ-044 A bench SHALL cover: key_i=16'h1234, three entries of 9,9,9,9 -> fail_o pulses 3 times, attempts_o 1,2,3, locked_o=1, and a subsequent correct PIN is ignored.
REQ-045 A bench SHALL cover: digit_valid_i and enter_i asserted in the same cycle with cnt==3 -> enter ignored and digit dropped; digit_i=4'hA -> ignored; enroll of 0,0,0,0 -> fail_o pulse with attempts unchanged.
REQ-046 A bench SHALL cover: with PIN_LOCKOUT_TIMER_EN and LOCKOUT_CYCLES=16, locked_o high for exactly 16 cycles, then IDLE with attempts_o=0; without the macro, locked_o stays high until rst_ni.
REQ-047 A bench SHALL cover: rst_ni asserted in the WRITE cycle -> wenable_o=0 immediately and all outputs 0.

Source files
------------

// File: rtl/pin_ctrl.sv
// Keypad PIN controller: collects four BCD digits, verifies against or enrolls into a key store.
// Optional macro PIN_LOCKOUT_TIMER_EN adds a timed exit from lockout; otherwise lockout holds until reset.
module pin_ctrl #(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  digit_i,
  input  logic        digit_valid_i,
  input  logic        enter_i,
  input  logic        clear_i,
  input  logic        enroll_i,
  input  logic [15:0] key_i,
  input  logic        key_blank_i,
  output logic [15:0] key_o,
  output logic        wenable_o,
  output logic        unlock_o,
  output logic        fail_o,
  output logic        locked_o,
  output logic [1:0]  attempts_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_UNLOCKED = 3'd4;
  localparam logic [2:0] S_LOCKOUT  = 3'd5;

  localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);

  logic [2:0]  state_q, state_d;
  logic [15:0] pin_q, pin_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        enroll_q, enroll_d;
  logic [1:0]  attempts_q, attempts_d;
  logic [15:0] key_q, key_d;
  logic        wen_q, wen_d;
  logic        unlock_q, unlock_d;
  logic        fail_q, fail_d;
  logic        locked_q, locked_d;

`ifdef PIN_LOCKOUT_TIMER_EN
  localparam int unsigned TIMER_W = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
  logic [TIMER_W-1:0] timer_q, timer_d;
`else
  // LOCKOUT_CYCLES only matters for the timed-lockout build.
  if (LOCKOUT_CYCLES == 0) begin : g_no_timer
  end
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    pin_d      = pin_q;
    cnt_d      = cnt_q;
    enroll_d   = enroll_q;
    attempts_d = attempts_q;
    key_d      = 16'h0000;
    wen_d      = 1'b0;
    fail_d     = 1'b0;
`ifdef PIN_LOCKOUT_TIMER_EN
    timer_d    = timer_q;
`endif
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (clear_i) begin
          state_d  = S_IDLE;
          pin_d    = 16'h0000;
          cnt_d    = 3'd0;
          enroll_d = 1'b0;
        end else if (enroll_i && state_q == S_IDLE && key_blank_i) begin
          enroll_d = 1'b1;
        end else if (enter_i) begin
          if (cnt_q == 3'd4) begin
            if (enroll_q) begin
              if (pin_q != 16'h0000) begin
                state_d = S_WRITE;
                wen_d   = 1'b1;
                key_d   = pin_q;
              end else begin
                // Zero PIN is reserved for blank; CHECK reports the rejection.
                state_d = S_CHECK;
              end
            end else if (!key_blank_i) begin
              state_d = S_CHECK;
            end
          end
        end else if (digit_valid_i && digit_i <= 4'd9 && cnt_q != 3'd4) begin
          state_d = S_COLLECT;
          pin_d   = {pin_q[11:0], digit_i};
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        pin_d   = 16'h0000;
        cnt_d   = 3'd0;
        if (enroll_q) begin
          fail_d   = 1'b1;
          enroll_d = 1'b0;
        end else if (pin_q == key_i) begin
          state_d    = S_UNLOCKED;
          attempts_d = 2'd0;
        end else begin
          fail_d     = 1'b1;
          attempts_d = (attempts_q == MAX_ATT) ? attempts_q : attempts_q + 2'd1;
          if (attempts_d == MAX_ATT) begin
            state_d = S_LOCKOUT;
`ifdef PIN_LOCKOUT_TIMER_EN
            timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
`endif
          end
        end
      end
      S_WRITE: begin
        state_d    = S_IDLE;
        pin_d      = 16'h0000;
        cnt_d      = 3'd0;
        enroll_d   = 1'b0;
        attempts_d = 2'd0;
      end
      S_UNLOCKED: begin
        if (clear_i) begin
          state_d  = S_IDLE;
          pin_d    = 16'h0000;
          cnt_d    = 3'd0;
          enroll_d = 1'b0;
        end else if (enroll_i) begin
          state_d  = S_IDLE;
          enroll_d = 1'b1;
        end
      end
      S_LOCKOUT: begin
`ifdef PIN_LOCKOUT_TIMER_EN
        if (timer_q == '0) begin
          state_d    = S_IDLE;
          attempts_d = 2'd0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    unlock_d = (state_d == S_UNLOCKED);
    locked_d = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pin_q      <= 16'h0000;
      cnt_q      <= 3'd0;
      enroll_q   <= 1'b0;
      attempts_q <= 2'd0;
      key_q      <= 16'h0000;
      wen_q      <= 1'b0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pin_q      <= pin_d;
      cnt_q      <= cnt_d;
      enroll_q   <= enroll_d;
      attempts_q <= attempts_d;
      key_q      <= key_d;
      wen_q      <= wen_d;
      unlock_q   <= unlock_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
    end
  end

`ifdef PIN_LOCKOUT_TIMER_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`endif

  assign key_o      = key_q;
  assign wenable_o  = wen_q;
  assign unlock_o   = unlock_q;
  assign fail_o     = fail_q;
  assign locked_o   = locked_q;
  assign attempts_o = attempts_q;

endmodule

// File: tb/tb_pin_ctrl.sv
// Bench for pin_ctrl: directed scenarios plus random keypad traffic against a digit-queue reference model.
// Timed-lockout expectations follow PIN_LOCKOUT_TIMER_EN when defined.
module tb_pin_ctrl;

  localparam int MAX_ATT  = 3;
  localparam int LOCK_CYC = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  digit_i;
  logic        digit_valid_i, enter_i, clear_i, enroll_i;
  logic [15:0] key_i;
  logic        key_blank_i;
  logic [15:0] key_o;
  logic        wenable_o, unlock_o, fail_o, locked_o;
  logic [1:0]  attempts_o;

  pin_ctrl #(.MAX_ATTEMPTS(MAX_ATT), .LOCKOUT_CYCLES(LOCK_CYC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .digit_i(digit_i), .digit_valid_i(digit_valid_i),
    .enter_i(enter_i), .clear_i(clear_i), .enroll_i(enroll_i), .key_i(key_i),
    .key_blank_i(key_blank_i), .key_o(key_o), .wenable_o(wenable_o), .unlock_o(unlock_o),
    .fail_o(fail_o), .locked_o(locked_o), .attempts_o(attempts_o)
  );

  always #5 clk_i = ~clk_i;

  // Key store outside the DUT; it commits a write at the edge ending the write cycle.
  logic [15:0] store;
  logic [15:0] wr_key;
  bit          wr_pend;
  assign key_i       = store;
  assign key_blank_i = (store == 16'h0000);

  int n_tests = 0;
  int n_fail  = 0;
  int lock_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: entered digits as a queue, plus coarse user-visible modes.
  int          m_dig[$];
  bit          m_enr, m_unl, m_lck;
  int          m_att, m_left, m_pend;  // m_pend: 0 none, 1 verify, 2 zero-enroll reject, 3 write cycle
  logic [15:0] m_pin;
  bit          e_wen, e_fail;
  logic [15:0] e_key;

  function automatic logic [15:0] pin_value();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_dig.delete();
    m_enr = 0; m_unl = 0; m_lck = 0;
    m_att = 0; m_left = 0; m_pend = 0; m_pin = '0;
    e_wen = 0; e_fail = 0; e_key = '0;
    wr_pend = 0;
  endtask

  task automatic model_step();
    e_wen = 0; e_key = '0; e_fail = 0;
    if (m_pend == 1) begin
      m_pend = 0;
      if (m_pin == key_i) begin
        m_unl = 1; m_att = 0;
      end else begin
        e_fail = 1;
        if (m_att < MAX_ATT) m_att++;
        if (m_att == MAX_ATT) begin m_lck = 1; m_left = LOCK_CYC; end
      end
    end else if (m_pend == 2) begin
      m_pend = 0; e_fail = 1; m_enr = 0;
    end else if (m_pend == 3) begin
      m_pend = 0; m_att = 0; m_enr = 0;
    end else if (m_lck) begin
`ifdef PIN_LOCKOUT_TIMER_EN
      m_left--;
      if (m_left == 0) begin m_lck = 0; m_att = 0; end
`endif
    end else if (m_unl) begin
      if (clear_i) begin m_unl = 0; m_enr = 0; end
      else if (enroll_i) begin m_unl = 0; m_enr = 1; end
    end else begin
      if (clear_i) begin
        m_dig.delete(); m_enr = 0;
      end else if (enroll_i && m_dig.size() == 0 && key_blank_i) begin
        m_enr = 1;
      end else if (enter_i) begin
        if (m_dig.size() == 4) begin
          m_pin = pin_value();
          if (m_enr) begin
            if (m_pin != 0) begin e_wen = 1; e_key = m_pin; m_pend = 3; end
            else m_pend = 2;
            m_dig.delete();
          end else if (!key_blank_i) begin
            m_pend = 1;
            m_dig.delete();
          end
        end
      end else if (digit_valid_i && digit_i <= 4'd9 && m_dig.size() < 4) begin
        m_dig.push_back(int'(digit_i));
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("wenable", wenable_o, e_wen);
    check_eq("key", key_o, e_key);
    check_eq("fail", fail_o, e_fail);
    check_eq("unlock", unlock_o, m_unl);
    check_eq("locked", locked_o, m_lck);
    check_eq("attempts", attempts_o, m_att);
  endtask

  // One clock: drive at negedge, advance model, sample at following negedge.
  task automatic cycle(input logic dv, input logic [3:0] d, input logic en, input logic cl, input logic er);
    digit_valid_i = dv; digit_i = d; enter_i = en; clear_i = cl; enroll_i = er;
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    digit_valid_i = 0; enter_i = 0; clear_i = 0; enroll_i = 0;
    if (locked_o) lock_seen++;
    compare_outputs();
    if (e_wen) begin wr_pend = 1; wr_key = e_key; end
    else if (wr_pend) begin store = wr_key; wr_pend = 0; end
  endtask

  task automatic idle();            cycle(0, 4'd0, 0, 0, 0); endtask
  task automatic dig(input int d);  cycle(1, 4'(d), 0, 0, 0); endtask
  task automatic enter();           cycle(0, 4'd0, 1, 0, 0); endtask
  task automatic enroll();          cycle(0, 4'd0, 0, 0, 1); endtask
  task automatic clear();           cycle(0, 4'd0, 0, 1, 0); endtask

  task automatic pin4(input int a, input int b, input int c, input int d);
    dig(a); dig(b); dig(c); dig(d);
  endtask

  task automatic do_reset();
    rst_ni = 0;
    digit_valid_i = 0; enter_i = 0; clear_i = 0; enroll_i = 0;
    model_reset();
    #1;
    compare_outputs();
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lk_run;
    rst_ni = 0; digit_i = 0; digit_valid_i = 0; enter_i = 0; clear_i = 0; enroll_i = 0;
    store = 16'h0000;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    compare_outputs();
    rst_ni = 1;

    // Enrollment on a blank store writes the PIN for one cycle.
    enroll(); pin4(1, 2, 3, 4); enter();
    check_eq("enroll_wen", wenable_o, 1);
    check_eq("enroll_key", key_o, 16'h1234);
    idle();
    check_eq("enroll_wen_off", wenable_o, 0);

    // Correct PIN unlocks two cycles after enter.
    pin4(1, 2, 3, 4); enter();
    check_eq("unlock_early", unlock_o, 0);
    idle();
    check_eq("unlock", unlock_o, 1);
    check_eq("unlock_att", attempts_o, 0);
    clear();
    check_eq("unlock_clear", unlock_o, 0);

    // Three wrong PINs lock the pad; a later correct PIN is ignored.
    for (int k = 1; k <= 3; k++) begin
      pin4(9, 9, 9, 9); enter();
      if (k == 3) lock_seen = 0;
      idle();
      check_eq("bad_fail", fail_o, 1);
      check_eq("bad_att", attempts_o, k);
    end
    check_eq("lock_set", locked_o, 1);
    pin4(1, 2, 3, 4); enter(); idle(); idle();
    check_eq("lock_ignores_pin", unlock_o, 0);
`ifdef PIN_LOCKOUT_TIMER_EN
    for (int n = 0; n < 100 && locked_o; n++) idle();
    check_eq("lock_cycles", lock_seen, LOCK_CYC);
    check_eq("lock_exit_att", attempts_o, 0);
`else
    repeat (40) idle();
    check_eq("lock_holds", locked_o, 1);
`endif
    do_reset();
    check_eq("lock_reset", locked_o, 0);

    // Coincident digit+enter drops both; digit A is ignored.
    store = 16'h1234;
    pin4(1, 2, 3, 9); clear();
    dig(1); dig(2); dig(3); cycle(1, 4'd4, 1, 0, 0); enter(); idle(); idle();
    check_eq("drop_fail", fail_o, 0);
    check_eq("drop_unlock", unlock_o, 0);
    dig(4); enter(); idle();
    check_eq("drop_then_unlock", unlock_o, 1);
    clear();
    dig(1); dig(2); dig(10); dig(3); dig(4); enter(); idle();
    check_eq("hex_ignored", unlock_o, 1);

    // Enroll from unlocked with an all-zero PIN is rejected.
    enroll();
    check_eq("enroll_relock", unlock_o, 0);
    pin4(0, 0, 0, 0); enter(); idle();
    check_eq("zero_fail", fail_o, 1);
    check_eq("zero_att", attempts_o, 0);
    check_eq("zero_no_write", store, 16'h1234);

    // Reset during the write cycle kills the strobe at once.
    do_reset();
    store = 16'h0000;
    enroll(); pin4(5, 6, 7, 8); enter();
    check_eq("wr_before_rst", wenable_o, 1);
    do_reset();
    check_eq("wr_rst_wen", wenable_o, 0);
    check_eq("wr_rst_key", key_o, 0);
    check_eq("wr_rst_store", store, 16'h0000);

    // Random traffic.
    lk_run = 0;
    for (int it = 0; it < 3000; it++) begin
      logic dv, en, cl, er;
      logic [3:0] d;
      int tgt, p;
      dv = ($urandom % 2) == 0;
      en = ($urandom % 7) == 0;
      cl = ($urandom % 25) == 0;
      er = ($urandom % 20) == 0;
      tgt = m_enr ? int'($urandom % 65536) : int'(store);
      p = m_dig.size();
      if (p < 4 && ($urandom % 5) != 0) d = 4'((tgt >> (4 * (3 - p))) & 15);
      else d = 4'($urandom % 16);
      if (d > 4'd9 && ($urandom % 2) == 0) d = 4'd0;
      cycle(dv, d, en, cl, er);
      lk_run = locked_o ? lk_run + 1 : 0;
      if (lk_run > 30 || ($urandom % 400) == 0) begin
        do_reset();
        lk_run = 0;
        if (($urandom % 3) == 0) store = 16'h0000;
        else store = {4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10), 4'($urandom % 10)};
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
